wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Two-master pipelined WISHBONE arbiter that shares the single instruction/data memory port between the FETCH stage (master 0, read-only) and the MEMORY stage (master 1, read/write). Grant is round-robin with a starvation limit: a master may issue at most MAX_BURST requests while the other waits, then it is stalled until its outstanding requests drain and the grant moves. It sits between the CPU pipeline masters and the memory slave, adds no latency to the granted master's path, and never breaks a WISHBONE cycle on either side.

## Interface
- AW, 16, address width
- DW, 16, data width
- MAX_BURST, 8, accepted requests per grant while the other master waits (≥1)
- clk_i  in  1  clock, all state on rising edge
- rst_ni  in  1  asynchronous, active-low reset
- m0_cyc_i, m0_stb_i  in  1  FETCH cycle/strobe
- m0_addr_i  in  AW  FETCH address
- m0_stall_o, m0_ack_o  out  1  FETCH stall/ack
- m0_data_o  out  DW  FETCH read data
- m1_cyc_i, m1_stb_i, m1_we_i  in  1  MEMORY cycle/strobe/write-enable
- m1_addr_i  in  AW; m1_data_i  in  DW  MEMORY address/write data
- m1_stall_o, m1_ack_o  out  1  MEMORY stall/ack
- m1_data_o  out  DW  MEMORY read data
- s_cyc_o, s_stb_o, s_we_o  out  1  slave cycle/strobe/write-enable
- s_addr_o  out  AW; s_data_o  out  DW  slave address/write data
- s_stall_i, s_ack_i  in  1  slave stall/ack
- s_data_i  in  DW  slave read data

## Operation
- State (registered): IDLE, GNT0, GNT1; registers last (last served master), out_cnt (3 bits), burst_cnt, yield.
- IDLE: only m0_cyc_i → GNT0; only m1_cyc_i → GNT1; both → master ≠ last. After reset last=0, so simultaneous requests go to m1 first.
- GNTx: granted master x drives the slave; s_cyc_o = mx_cyc_i, s_stb_o = mx_stb_i & ~block, addr/we/data muxed from x (m0: we=0, data=0).
- block = yield | (out_cnt==7). mx_stall_o = s_stall_i | block; non-granted master stall_o = 1.
- Accept = s_stb_o & ~s_stall_i: out_cnt +1; ack (s_ack_i & s_cyc_o): out_cnt −1; both same cycle: unchanged.
- burst_cnt increments on accept while other master's cyc is high; reaching MAX_BURST sets yield. burst_cnt/yield clear on every grant change, and when the other master drops cyc (yield released, x resumes).
- Yield with out_cnt==0 (including the cycle the last ack arrives) → direct GNTx→GNTy, last=x. Master x keeps its cyc; it sees stall only.
- Granted master drops cyc: out_cnt cleared (cycle abort, late acks discarded since s_cyc_o=0), next state from IDLE rules with last=x (other waiting → GNTy directly).
- mx_ack_o = s_ack_i & s_cyc_o & grant==x; m0_data_o = m1_data_o = s_data_i.
- Slave never receives cyc from a non-granted master; grant never changes while out_cnt≠0 and cyc held.

## Timing
- Reset (rst_ni=0, any time, mid-transfer included): state IDLE, counters 0, yield 0, last 0. Outputs: s_cyc_o=s_stb_o=s_we_o=0, s_addr_o=s_data_o=0, both stall_o=1, both ack_o=0.
- Grant latency: request in IDLE at cycle n → granted at n+1; strobe reaches slave combinationally from then, zero added latency, stall/ack combinational back to master.
- Forced switch: last ack at cycle k with yield set → GNTy at k+1.
- Arithmetic: out_cnt saturates by blocking at 7, never wraps; burst_cnt width ⌈log2(MAX_BURST+1)⌉, never exceeds MAX_BURST.

## Structure
- Package wb_arbiter_pkg: state enum (IDLE, GNT0, GNT1), OUT_MAX=7 constant.
- Single flat module; no sub-module — a 2:1 request mux is too small to separate.
- Formal wrapper reuses the team's WISHBONE master/slave property checkers on all three ports.

## Test plan
- Reset then m0 alone reads 0x0100..0x0103, slave ack 1 cycle later → grant GNT0 at cycle 1, m0_ack_o for each, m1_stall_o=1 throughout.
- Both cyc rise together after reset → GNT1 first; m1 write 0x0200←0xBEEF has s_we_o=1, s_data_o=0xBEEF; m1 drops cyc → GNT0 next cycle.
- m0 streams continuously, m1 waiting, MAX_BURST=8 → exactly 8 accepts, m0_stall_o=1 from 9th, switch to GNT1 the cycle after the 8th ack.
- Slave withholds acks → 7 accepted, then s_stb_o=0 and stall_o=1 until an ack arrives.
- m0 drops cyc with 2 outstanding → s_cyc_o=0 same cycle, late s_ack_i produces no m0_ack_o/m1_ack_o, out_cnt=0.
- rst_ni pulled low mid-burst → all outputs at reset values asynchronously; after release IDLE, simultaneous requests grant m1.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared types for the two-master WISHBONE arbiter: grant-state encoding,
// the outstanding-request ceiling and the idle grant-selection rule.
package wb_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_e;

    // Outstanding-request counter is 3 bits; it blocks at this value instead of wrapping.
    localparam logic [2:0] OUT_MAX = 3'd7;

    // Grant choice from the idle rules: a lone requester wins. When both request,
    // the master that was not served last wins.
    function automatic state_e pick_grant(input logic c0, input logic c1, input logic last);
        state_e g;
        if (c0 && c1) begin
            g = last ? GNT0 : GNT1;
        end else if (c0) begin
            g = GNT0;
        end else if (c1) begin
            g = GNT1;
        end else begin
            g = IDLE;
        end
        return g;
    endfunction

endpackage

// File: rtl/wb_arbiter.sv
// Two-master pipelined WISHBONE arbiter. Master 0 (FETCH, read-only) and
// master 1 (MEMORY, read/write) share one slave port. The granted master is
// wired straight through to the slave, so no latency is added. A grant ends
// when its master drops cyc. It also ends when the master has had MAX_BURST
// accepts while the other master waited and its outstanding requests have drained.
//
// Handshake (all three ports, pipelined WISHBONE): a request transfers at the
// rising edge where cyc & stb & ~stall is true; the slave returns exactly one
// ack per transferred request, in order, while cyc is held; dropping cyc
// aborts the cycle and any later ack is ignored.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int AW        = 16,
    parameter int DW        = 16,
    parameter int MAX_BURST = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,

    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic [AW-1:0] m0_addr_i,
    output logic          m0_stall_o,
    output logic          m0_ack_o,
    output logic [DW-1:0] m0_data_o,

    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic          m1_we_i,
    input  logic [AW-1:0] m1_addr_i,
    input  logic [DW-1:0] m1_data_i,
    output logic          m1_stall_o,
    output logic          m1_ack_o,
    output logic [DW-1:0] m1_data_o,

    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic          s_we_o,
    output logic [AW-1:0] s_addr_o,
    output logic [DW-1:0] s_data_o,
    input  logic          s_stall_i,
    input  logic          s_ack_i,
    input  logic [DW-1:0] s_data_i,

    // Observation of internal state for checkers and debug.
    output logic [1:0]    dbg_state_o,
    output logic [2:0]    dbg_out_cnt_o
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BURST_LIM = BW'(MAX_BURST);

    state_e        state_q, state_d;
    logic          last_q, last_d;
    logic [2:0]    out_cnt_q, out_cnt_d;
    logic [BW-1:0] burst_q, burst_d;
    logic          yield_q, yield_d;

    logic          gnt0, gnt1;
    logic          own_cyc, own_stb, other_cyc;
    logic          block;
    logic          accept, ack;
    logic [2:0]    cnt_step;
    logic [BW-1:0] burst_inc;
    state_e        other_gnt;

    assign gnt0 = (state_q == GNT0);
    assign gnt1 = (state_q == GNT1);

    // Request mux: the granted master's cyc/stb; the other master's cyc
    // decides whether it is being made to wait.
    always_comb begin
        own_cyc   = 1'b0;
        own_stb   = 1'b0;
        other_cyc = 1'b0;
        other_gnt = IDLE;
        if (gnt0) begin
            own_cyc   = m0_cyc_i;
            own_stb   = m0_stb_i;
            other_cyc = m1_cyc_i;
            other_gnt = GNT1;
        end else if (gnt1) begin
            own_cyc   = m1_cyc_i;
            own_stb   = m1_stb_i;
            other_cyc = m0_cyc_i;
            other_gnt = GNT0;
        end
    end

    // Stop new requests when yielding or when the outstanding count is at its ceiling.
    assign block = yield_q | (out_cnt_q == OUT_MAX);

    assign s_cyc_o  = own_cyc;
    assign s_stb_o  = own_cyc & own_stb & ~block;
    assign s_we_o   = gnt1 & m1_we_i;
    assign s_addr_o = gnt0 ? m0_addr_i : (gnt1 ? m1_addr_i : '0);
    assign s_data_o = gnt1 ? m1_data_i : '0;

    assign accept = s_stb_o & ~s_stall_i;
    assign ack    = s_ack_i & s_cyc_o;

    // Stall and ack go straight back to the granted master; the waiting
    // master (and both masters while idle) are held off with stall.
    assign m0_stall_o = gnt0 ? (s_stall_i | block) : 1'b1;
    assign m1_stall_o = gnt1 ? (s_stall_i | block) : 1'b1;
    assign m0_ack_o   = ack & gnt0;
    assign m1_ack_o   = ack & gnt1;
    assign m0_data_o  = s_data_i;
    assign m1_data_o  = s_data_i;

    assign dbg_state_o   = state_q;
    assign dbg_out_cnt_o = out_cnt_q;

    assign burst_inc = burst_q + 1'b1;

    // Outstanding count after this cycle's accept/ack. It cannot wrap: accept
    // is blocked at the ceiling, and a spurious ack at zero is ignored.
    always_comb begin
        cnt_step = out_cnt_q;
        if (accept && !ack) begin
            cnt_step = out_cnt_q + 3'd1;
        end else if (ack && !accept && (out_cnt_q != 3'd0)) begin
            cnt_step = out_cnt_q - 3'd1;
        end
    end

    // Grant FSM next state plus counter/yield bookkeeping.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        out_cnt_d = out_cnt_q;
        burst_d   = burst_q;
        yield_d   = yield_q;
        case (state_q)
            IDLE: begin
                state_d   = pick_grant(m0_cyc_i, m1_cyc_i, last_q);
                out_cnt_d = 3'd0;
                burst_d   = '0;
                yield_d   = 1'b0;
            end
            GNT0, GNT1: begin
                if (!own_cyc) begin
                    // Cycle ended or aborted: drop outstanding requests. The
                    // idle rules with last = this master leave a waiting
                    // master as the only candidate.
                    last_d    = gnt1;
                    out_cnt_d = 3'd0;
                    burst_d   = '0;
                    yield_d   = 1'b0;
                    state_d   = other_cyc ? other_gnt : IDLE;
                end else if (yield_q && other_cyc && (cnt_step == 3'd0)) begin
                    // Burst limit reached and everything drained: hand over
                    // directly. The current master keeps cyc and just sees stall.
                    last_d    = gnt1;
                    out_cnt_d = 3'd0;
                    burst_d   = '0;
                    yield_d   = 1'b0;
                    state_d   = other_gnt;
                end else begin
                    out_cnt_d = cnt_step;
                    if (!other_cyc) begin
                        // Nobody is waiting any more: burst limit no longer applies.
                        burst_d = '0;
                        yield_d = 1'b0;
                    end else if (accept) begin
                        burst_d = burst_inc;
                        if (burst_inc == BURST_LIM) begin
                            yield_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                out_cnt_d = 3'd0;
                burst_d   = '0;
                yield_d   = 1'b0;
            end
        endcase
    end

    // State and bookkeeping registers, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            last_q    <= 1'b0;
            out_cnt_q <= 3'd0;
            burst_q   <= '0;
            yield_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            out_cnt_q <= out_cnt_d;
            burst_q   <= burst_d;
            yield_q   <= yield_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: a pipelined slave model that can withhold acks,
// master driver tasks, a scoreboard of expected read data per master, and
// one task per scenario.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int MAX_BURST = 8;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          m0_cyc_i = 1'b0, m0_stb_i = 1'b0;
    logic [AW-1:0] m0_addr_i = '0;
    logic          m0_stall_o, m0_ack_o;
    logic [DW-1:0] m0_data_o;
    logic          m1_cyc_i = 1'b0, m1_stb_i = 1'b0, m1_we_i = 1'b0;
    logic [AW-1:0] m1_addr_i = '0;
    logic [DW-1:0] m1_data_i = '0;
    logic          m1_stall_o, m1_ack_o;
    logic [DW-1:0] m1_data_o;
    logic          s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0] s_addr_o;
    logic [DW-1:0] s_data_o;
    logic          s_stall_i = 1'b0;
    logic          s_ack_i;
    logic [DW-1:0] s_data_i;
    logic [1:0]    dbg_state_o;
    logic [2:0]    dbg_out_cnt_o;

    int n_checks = 0;
    int n_fail = 0;

    wb_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_addr_i(m0_addr_i),
        .m0_stall_o(m0_stall_o), .m0_ack_o(m0_ack_o), .m0_data_o(m0_data_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i),
        .m1_stall_o(m1_stall_o), .m1_ack_o(m1_ack_o), .m1_data_o(m1_data_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_addr_o(s_addr_o), .s_data_o(s_data_o),
        .s_stall_i(s_stall_i), .s_ack_i(s_ack_i), .s_data_i(s_data_i),
        .dbg_state_o(dbg_state_o), .dbg_out_cnt_o(dbg_out_cnt_o)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no summary, expected completion");
        $fatal(1, "watchdog");
    end

    // Slave read data is a fixed function of the address.
    function automatic logic [DW-1:0] rd_val(input logic [AW-1:0] a);
        return a ^ 16'hA5C3;
    endfunction

    // ---------------- slave model ----------------
    // Accepts on stb & ~stall, acks one cycle later in order. It keeps acking
    // requests it accepted even after cyc drops, to produce late acks.
    logic          ack_en = 1'b1;
    logic [AW-1:0] pend_q[$];

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q.delete();
            s_ack_i  <= 1'b0;
            s_data_i <= '0;
        end else begin
            if (s_stb_o && !s_stall_i) pend_q.push_back(s_addr_o);
            if (ack_en && pend_q.size() > 0) begin
                s_ack_i  <= 1'b1;
                s_data_i <= rd_val(pend_q.pop_front());
            end else begin
                s_ack_i  <= 1'b0;
                s_data_i <= '0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp0_q[$], exp1_q[$];
    logic [DW-1:0] sb_exp0, sb_exp1;

    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (m0_ack_o) begin
                n_checks++;
                if (exp0_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL m0_ack_spurious: got ack data %h, expected no ack", m0_data_o);
                end else begin
                    sb_exp0 = exp0_q.pop_front();
                    if (m0_data_o !== sb_exp0) begin
                        n_fail++;
                        $display("FAIL m0_data: got %h expected %h", m0_data_o, sb_exp0);
                    end
                end
            end
            if (m1_ack_o) begin
                n_checks++;
                if (exp1_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL m1_ack_spurious: got ack data %h, expected no ack", m1_data_o);
                end else begin
                    sb_exp1 = exp1_q.pop_front();
                    if (m1_data_o !== sb_exp1) begin
                        n_fail++;
                        $display("FAIL m1_data: got %h expected %h", m1_data_o, sb_exp1);
                    end
                end
            end
            if (m0_cyc_i && m0_stb_i && !m0_stall_o) exp0_q.push_back(rd_val(m0_addr_i));
            if (m1_cyc_i && m1_stb_i && !m1_stall_o) exp1_q.push_back(rd_val(m1_addr_i));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic m0_read(input logic [AW-1:0] a, output bit ok);
        ok = 1'b0;
        m0_stb_i  = 1'b1;
        m0_addr_i = a;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_i);
            if (!m0_stall_o) ok = 1'b1;
            tick();
            if (ok) break;
        end
        m0_stb_i = 1'b0;
    endtask

    task automatic m1_access(input logic [AW-1:0] a, input logic we,
                             input logic [DW-1:0] d, output bit ok);
        ok = 1'b0;
        m1_stb_i  = 1'b1;
        m1_we_i   = we;
        m1_addr_i = a;
        m1_data_i = d;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_i);
            if (!m1_stall_o) ok = 1'b1;
            tick();
            if (ok) break;
        end
        m1_stb_i = 1'b0;
        m1_we_i  = 1'b0;
    endtask

    // Wait until every expected ack has been seen.
    task automatic drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (exp0_q.size() == 0 && exp1_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        n_checks++;
        if ({s_cyc_o, s_stb_o, s_we_o, m0_stall_o, m1_stall_o, m0_ack_o, m1_ack_o} !== 7'b0001100) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected %b",
                     {s_cyc_o, s_stb_o, s_we_o, m0_stall_o, m1_stall_o, m0_ack_o, m1_ack_o}, 7'b0001100);
        end
        n_checks++;
        if (s_addr_o !== 16'h0 || s_data_o !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_bus: got addr %h data %h expected 0000 0000", s_addr_o, s_data_o);
        end
        n_checks++;
        if (dbg_state_o !== IDLE || dbg_out_cnt_o !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_state: got state %0d cnt %0d expected 0 0", dbg_state_o, dbg_out_cnt_o);
        end
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_m0_reads();
        bit ok;
        m0_cyc_i = 1'b1;
        @(negedge clk_i);
        n_checks++;
        if (dbg_state_o !== IDLE || m0_stall_o !== 1'b1) begin
            n_fail++;
            $display("FAIL m0_pre_grant: got state %0d stall %b expected 0 1", dbg_state_o, m0_stall_o);
        end
        tick();
        n_checks++;
        if (dbg_state_o !== GNT0) begin
            n_fail++;
            $display("FAIL m0_grant_latency: got state %0d expected %0d", dbg_state_o, GNT0);
        end
        // Slave stall is passed straight back while the strobe is presented.
        s_stall_i = 1'b1;
        m0_stb_i  = 1'b1;
        m0_addr_i = 16'h0100;
        @(negedge clk_i);
        n_checks++;
        if (m0_stall_o !== 1'b1 || s_stb_o !== 1'b1 || s_addr_o !== 16'h0100) begin
            n_fail++;
            $display("FAIL m0_slave_stall: got stall %b stb %b addr %h expected 1 1 0100",
                     m0_stall_o, s_stb_o, s_addr_o);
        end
        tick();
        s_stall_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m0_read(16'h0100 + 16'(i), ok);
            n_checks++;
            if (!ok || m1_stall_o !== 1'b1) begin
                n_fail++;
                $display("FAIL m0_read_%0d: got accepted %b m1_stall %b expected 1 1", i, ok, m1_stall_o);
            end
        end
        drain(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL m0_drain: got %0d acks missing expected 0", exp0_q.size());
        end
        m0_cyc_i = 1'b0;
        tick();
        n_checks++;
        if (dbg_state_o !== IDLE) begin
            n_fail++;
            $display("FAIL m0_release: got state %0d expected %0d", dbg_state_o, IDLE);
        end
    endtask

    task automatic test_both_start();
        bit ok;
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        tick();
        m0_cyc_i = 1'b1;
        m1_cyc_i = 1'b1;
        tick();
        n_checks++;
        if (dbg_state_o !== GNT1) begin
            n_fail++;
            $display("FAIL both_first_grant: got state %0d expected %0d", dbg_state_o, GNT1);
        end
        m1_stb_i  = 1'b1;
        m1_we_i   = 1'b1;
        m1_addr_i = 16'h0200;
        m1_data_i = 16'hBEEF;
        @(negedge clk_i);
        n_checks++;
        if ({s_stb_o, s_we_o, m1_stall_o, m0_stall_o} !== 4'b1101 ||
            s_addr_o !== 16'h0200 || s_data_o !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL m1_write_bus: got stb/we/st1/st0 %b addr %h data %h expected 1101 0200 beef",
                     {s_stb_o, s_we_o, m1_stall_o, m0_stall_o}, s_addr_o, s_data_o);
        end
        tick();
        m1_stb_i = 1'b0;
        m1_we_i  = 1'b0;
        drain(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL m1_write_ack: got %0d acks missing expected 0", exp1_q.size());
        end
        m1_cyc_i = 1'b0;
        @(negedge clk_i);
        n_checks++;
        if (s_cyc_o !== 1'b0) begin
            n_fail++;
            $display("FAIL m1_drop_cyc: got s_cyc %b expected 0", s_cyc_o);
        end
        tick();
        n_checks++;
        if (dbg_state_o !== GNT0) begin
            n_fail++;
            $display("FAIL handover_m0: got state %0d expected %0d", dbg_state_o, GNT0);
        end
        m0_read(16'h0110, ok);
        drain(ok);
        m0_cyc_i = 1'b0;
        tick();
    endtask

    task automatic test_burst_limit();
        bit ok, acc, stall_leak;
        int accepts, acks, ack8, sw;
        accepts = 0; acks = 0; ack8 = -100; sw = -1; stall_leak = 1'b0;
        m0_cyc_i = 1'b1;
        tick();
        m1_cyc_i  = 1'b1;
        m0_stb_i  = 1'b1;
        m0_addr_i = 16'h0300;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (dbg_state_o == GNT1) begin
                sw = i;
                break;
            end
            acc = !m0_stall_o;
            if (m0_ack_o) begin
                acks++;
                if (acks == MAX_BURST) ack8 = i;
            end
            if (accepts >= MAX_BURST && acc) stall_leak = 1'b1;
            if (acc) accepts++;
            tick();
            if (acc) m0_addr_i = m0_addr_i + 16'd1;
        end
        m0_stb_i = 1'b0;
        n_checks++;
        if (accepts != MAX_BURST || stall_leak) begin
            n_fail++;
            $display("FAIL burst_accepts: got %0d leak %b expected %0d 0", accepts, stall_leak, MAX_BURST);
        end
        n_checks++;
        if (sw != ack8 + 1) begin
            n_fail++;
            $display("FAIL burst_switch: got switch cycle %0d expected %0d", sw, ack8 + 1);
        end
        tick();
        m1_access(16'h0400, 1'b0, 16'h0, ok);
        drain(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL burst_drain: got %0d/%0d missing expected 0/0", exp0_q.size(), exp1_q.size());
        end
        m1_cyc_i = 1'b0;
        tick();
        n_checks++;
        if (dbg_state_o !== GNT0) begin
            n_fail++;
            $display("FAIL burst_return: got state %0d expected %0d", dbg_state_o, GNT0);
        end
        m0_cyc_i = 1'b0;
        tick();
    endtask

    task automatic test_withhold_acks();
        bit ok, acc, found;
        int accepts;
        accepts = 0; found = 1'b0;
        ack_en   = 1'b0;
        m0_cyc_i = 1'b1;
        tick();
        m0_stb_i  = 1'b1;
        m0_addr_i = 16'h0500;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_i);
            acc = !m0_stall_o;
            if (acc) accepts++;
            tick();
            if (acc) m0_addr_i = m0_addr_i + 16'd1;
        end
        n_checks++;
        if (accepts != 7) begin
            n_fail++;
            $display("FAIL withhold_accepts: got %0d expected 7", accepts);
        end
        @(negedge clk_i);
        n_checks++;
        if (s_stb_o !== 1'b0 || m0_stall_o !== 1'b1 || dbg_out_cnt_o !== 3'd7) begin
            n_fail++;
            $display("FAIL withhold_block: got stb %b stall %b cnt %0d expected 0 1 7",
                     s_stb_o, m0_stall_o, dbg_out_cnt_o);
        end
        tick();
        ack_en   = 1'b1;
        m0_stb_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            if (!m0_stall_o) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL withhold_release: got stall stuck at 1 expected 0 after ack");
        end
        tick();
        drain(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL withhold_drain: got %0d acks missing expected 0", exp0_q.size());
        end
        m0_cyc_i = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        bit ok0, ok1;
        int late, bad;
        late = 0; bad = 0;
        ack_en   = 1'b0;
        m0_cyc_i = 1'b1;
        tick();
        m0_read(16'($urandom_range(16'h0600, 16'h06FF)), ok0);
        m0_read(16'($urandom_range(16'h0600, 16'h06FF)), ok1);
        n_checks++;
        if (!ok0 || !ok1 || dbg_out_cnt_o !== 3'd2) begin
            n_fail++;
            $display("FAIL abort_setup: got ok %b%b cnt %0d expected 11 2", ok0, ok1, dbg_out_cnt_o);
        end
        m0_cyc_i = 1'b0;
        @(negedge clk_i);
        n_checks++;
        if (s_cyc_o !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_cyc: got s_cyc %b expected 0", s_cyc_o);
        end
        tick();
        ack_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            if (s_ack_i) late++;
            if (m0_ack_o || m1_ack_o) bad++;
        end
        n_checks++;
        if (late != 2 || bad != 0) begin
            n_fail++;
            $display("FAIL abort_late_ack: got late %0d forwarded %0d expected 2 0", late, bad);
        end
        n_checks++;
        if (dbg_out_cnt_o !== 3'd0 || dbg_state_o !== IDLE) begin
            n_fail++;
            $display("FAIL abort_state: got cnt %0d state %0d expected 0 0", dbg_out_cnt_o, dbg_state_o);
        end
        n_checks++;
        if (exp0_q.size() != 2) begin
            n_fail++;
            $display("FAIL abort_unacked: got %0d pending expected 2", exp0_q.size());
        end
        exp0_q.delete();
        tick();
    endtask

    task automatic test_random_mix();
        bit ok;
        logic [AW-1:0] a;
        for (int i = 0; i < 10; i++) begin
            a = 16'($urandom_range(0, 16'hFFFF));
            if ($urandom_range(0, 1) == 0) begin
                m0_cyc_i = 1'b1;
                tick();
                m0_read(a, ok);
            end else begin
                m1_cyc_i = 1'b1;
                tick();
                m1_access(a, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 16'hFFFF)), ok);
            end
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL mix_accept_%0d: got not accepted expected accepted", i);
            end
            drain(ok);
            m0_cyc_i = 1'b0;
            m1_cyc_i = 1'b0;
            tick();
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        ack_en   = 1'b0;
        m0_cyc_i = 1'b1;
        tick();
        m1_cyc_i = 1'b1;
        m0_read(16'h0700, ok);
        m0_read(16'h0701, ok);
        m0_stb_i  = 1'b1;
        m0_addr_i = 16'h0702;
        m1_stb_i  = 1'b1;
        m1_we_i   = 1'b1;
        m1_addr_i = 16'h0777;
        m1_data_i = 16'h1234;
        #2;
        rst_ni = 1'b0;
        #1;
        n_checks++;
        if ({s_cyc_o, s_stb_o, s_we_o, m0_stall_o, m1_stall_o, m0_ack_o, m1_ack_o} !== 7'b0001100 ||
            s_addr_o !== 16'h0 || s_data_o !== 16'h0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got %b addr %h data %h expected 0001100 0000 0000",
                     {s_cyc_o, s_stb_o, s_we_o, m0_stall_o, m1_stall_o, m0_ack_o, m1_ack_o}, s_addr_o, s_data_o);
        end
        n_checks++;
        if (dbg_state_o !== IDLE || dbg_out_cnt_o !== 3'd0) begin
            n_fail++;
            $display("FAIL midreset_state: got state %0d cnt %0d expected 0 0", dbg_state_o, dbg_out_cnt_o);
        end
        exp0_q.delete();
        exp1_q.delete();
        m0_stb_i = 1'b0; m0_cyc_i = 1'b0;
        m1_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_we_i = 1'b0;
        ack_en = 1'b1;
        tick();
        rst_ni = 1'b1;
        tick();
        m0_cyc_i = 1'b1;
        m1_cyc_i = 1'b1;
        tick();
        n_checks++;
        if (dbg_state_o !== GNT1) begin
            n_fail++;
            $display("FAIL midreset_regrant: got state %0d expected %0d", dbg_state_o, GNT1);
        end
        m0_cyc_i = 1'b0;
        m1_cyc_i = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        test_reset();
        test_m0_reads();
        test_both_start();
        test_burst_limit();
        test_withhold_acks();
        test_abort();
        test_random_mix();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
